user_session_ctrl: RTL and testbench
====================================

USER_SESSION_CTRL -- requirements
Module: user_session_ctrl

Interface
REQ-001 SHALL have parameter SESSION_CYCLES, default 16: session length in cycles before forced expiry (range 2..255).
REQ-002 SHALL have parameter LOCKOUT_CYCLES, default 4: cycles after expiry during which all requests are refused (range 1..255).
REQ-003 SHALL have port CLK input 1: single clock, rising edge.
REQ-004 SHALL have port RST_N input 1: asynchronous, active-low reset.
REQ-005 SHALL have port REQ input 1: access request strobe, sampled each cycle.
REQ-006 SHALL have port REQ_USER input 2: profile of the requester; numerically higher means higher priority.
REQ-007 SHALL have port REL input 1: release strobe from the current owner.
REQ-008 SHALL have port ACK output 1: one-cycle pulse, request granted.
REQ-009 SHALL have port NACK output 1: one-cycle pulse, request refused.
REQ-010 SHALL have port ACTIVE output 1: high while a session is open.
REQ-011 SHALL have port CUR_USER output 2: profile of the current owner; 0 when no session is open.
REQ-012 SHALL have port PREEMPT output 1: one-cycle pulse when the owner is displaced.
REQ-013 SHALL have port EXPIRED output 1: one-cycle pulse when a session times out.

Function
REQ-014 SHALL implement the states IDLE, ACTIVE and LOCKOUT.
REQ-015 SHALL respond to every cycle with REQ=1 by asserting exactly one of ACK or NACK on the following cycle (latency 1); with REQ=0, neither SHALL assert.
REQ-016 IDLE + REQ SHALL grant: go to ACTIVE, load CUR_USER=REQ_USER, load the session counter with SESSION_CYCLES-1.
REQ-017 ACTIVE + REQ with REQ_USER strictly greater than CUR_USER SHALL:
  - grant;
  - pulse PREEMPT;
  - replace CUR_USER;
  - reload the session counter.
REQ-018 ACTIVE + REQ with REQ_USER less than or equal to CUR_USER SHALL be NACKed with no state change; this includes a re-request by the same profile.
REQ-019 ACTIVE SHALL decrement the session counter every cycle; at count 0 without a grant it SHALL pulse EXPIRED, clear CUR_USER, go to LOCKOUT and load the counter with LOCKOUT_CYCLES-1.
REQ-020 LOCKOUT SHALL NACK every REQ, decrement the counter, and go to IDLE after count 0; REL SHALL be ignored.
REQ-021 ACTIVE + REL without REQ SHALL go to IDLE and clear CUR_USER, with no EXPIRED pulse.
REQ-022 Simultaneous REL and REQ in ACTIVE SHALL apply REL first, then evaluate REQ as in IDLE, so the request is granted.
REQ-023 Simultaneous expiry (count 0) and REQ in ACTIVE:
  - a strictly-higher REQ_USER SHALL win as a preemption, with no EXPIRED pulse;
  - otherwise expiry SHALL win and the REQ SHALL be NACKed.
REQ-024 REL in IDLE SHALL be ignored.
REQ-025 The counter SHALL be 8 bits wide and SHALL never wrap below 0.
REQ-026 ACTIVE SHALL be decoded directly from state, with no extra cycle.

Reset
REQ-027 RST_N low SHALL immediately force state=IDLE, counter=0, CUR_USER=0 and ACK=NACK=PREEMPT=EXPIRED=ACTIVE=0.
REQ-028 A reset asserted mid-session SHALL discard the session with no pulses; the first REQ after release SHALL be treated as in IDLE.

Structure
REQ-029 Shared package user_ctrl_pkg SHALL hold the state encoding, the profile width constant (2) and the default SESSION_CYCLES/LOCKOUT_CYCLES values.
REQ-030 The strictly-greater priority test SHALL be a combinational sub-module user_prio_cmp (inputs owner and requester profile, output higher flag).

Verification
REQ-031 Reset, then REQ=1 with REQ_USER=2 -> ACK next cycle, ACTIVE=1, CUR_USER=2.
REQ-032 Owner 2, REQ_USER=3 -> ACK+PREEMPT next cycle, CUR_USER=3; REQ_USER=1 or 2 -> NACK, CUR_USER unchanged.
REQ-033 Owner 1, no activity for 16 cycles -> EXPIRED pulse, CUR_USER=0; REQ on each of the next 4 cycles -> NACK; REQ on the 5th cycle -> ACK.
REQ-034 Owner 2, REL and REQ_USER=0 in the same cycle -> ACK, CUR_USER=0, ACTIVE=1, no PREEMPT.
REQ-035 Owner 1 at count 0 with REQ_USER=3 -> ACK+PREEMPT, no EXPIRED; same case with REQ_USER=1 -> EXPIRED+NACK.
REQ-036 RST_N low asynchronously mid-session -> all outputs 0 before the next clock edge.

Source files
------------

// File: rtl/user_ctrl_pkg.sv
// Shared definitions for the user session controller: state encoding,
// profile width and default session/lockout lengths.
package user_ctrl_pkg;

  localparam int PROF_W = 2;
  localparam int CNT_W  = 8;

  localparam int DEF_SESSION_CYCLES = 16;
  localparam int DEF_LOCKOUT_CYCLES = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_LOCKOUT = 2'd2
  } state_t;

endpackage

// File: rtl/user_prio_cmp.sv
// Combinational priority test: flags a requester whose profile strictly
// outranks the current owner.
module user_prio_cmp
  import user_ctrl_pkg::*;
(
  input  logic [PROF_W-1:0] owner,
  input  logic [PROF_W-1:0] requester,
  output logic              higher
);

  assign higher = (requester > owner);

endmodule

// File: rtl/user_session_ctrl.sv
// Single-owner session arbiter with priority preemption, timed expiry and a
// post-expiry lockout window. Responses are registered one cycle after REQ.
module user_session_ctrl
  import user_ctrl_pkg::*;
#(
  parameter int SESSION_CYCLES = DEF_SESSION_CYCLES,
  parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic [PROF_W-1:0] req_user,
  input  logic              rel,
  output logic              ack,
  output logic              nack,
  output logic              active,
  output logic [PROF_W-1:0] cur_user,
  output logic              preempt,
  output logic              expired
);

  localparam logic [CNT_W-1:0] SESS_LOAD = CNT_W'(SESSION_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCKOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PROF_W-1:0]  user_q, user_d;
  logic               ack_q, ack_d;
  logic               nack_q, nack_d;
  logic               pre_q, pre_d;
  logic               exp_q, exp_d;
  logic               higher;

  user_prio_cmp u_prio_cmp (
    .owner     (user_q),
    .requester (req_user),
    .higher    (higher)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      user_q  <= '0;
      ack_q   <= 1'b0;
      nack_q  <= 1'b0;
      pre_q   <= 1'b0;
      exp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      user_q  <= user_d;
      ack_q   <= ack_d;
      nack_q  <= nack_d;
      pre_q   <= pre_d;
      exp_q   <= exp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    user_d  = user_q;
    ack_d   = 1'b0;
    nack_d  = 1'b0;
    pre_d   = 1'b0;
    exp_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d = ST_ACTIVE;
          user_d  = req_user;
          cnt_d   = SESS_LOAD;
          ack_d   = 1'b1;
        end
      end
      ST_ACTIVE: begin
        // Release is applied before the request, so a simultaneous
        // request always sees an idle controller.
        if (rel) begin
          if (req) begin
            user_d = req_user;
            cnt_d  = SESS_LOAD;
            ack_d  = 1'b1;
          end else begin
            state_d = ST_IDLE;
            user_d  = '0;
            cnt_d   = '0;
          end
        end else if (req && higher) begin
          user_d = req_user;
          cnt_d  = SESS_LOAD;
          ack_d  = 1'b1;
          pre_d  = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = ST_LOCKOUT;
          user_d  = '0;
          cnt_d   = LOCK_LOAD;
          exp_d   = 1'b1;
          nack_d  = req;
        end else begin
          cnt_d  = cnt_q - CNT_ONE;
          nack_d = req;
        end
      end
      ST_LOCKOUT: begin
        nack_d = req;
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        user_d  = '0;
      end
    endcase
  end

  assign active   = (state_q == ST_ACTIVE);
  assign cur_user = user_q;
  assign ack      = ack_q;
  assign nack     = nack_q;
  assign preempt  = pre_q;
  assign expired  = exp_q;

endmodule

// File: tb/tb_user_session_ctrl.sv
// Bench for user_session_ctrl: directed scenarios plus randomized traffic,
// all compared against a cycle-indexed behavioural model of the session rules.
module tb_user_session_ctrl;

  localparam int S = 16;
  localparam int L = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req = 1'b0;
  logic [1:0] req_user = 2'd0;
  logic       rel = 1'b0;
  logic       ack, nack, active, preempt, expired;
  logic [1:0] cur_user;

  user_session_ctrl #(.SESSION_CYCLES(S), .LOCKOUT_CYCLES(L)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_user (req_user),
    .rel      (rel),
    .ack      (ack),
    .nack     (nack),
    .active   (active),
    .cur_user (cur_user),
    .preempt  (preempt),
    .expired  (expired)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: a session is an owner plus the absolute edge at which it expires;
  // lockout is the range of edges up to m_lock_last.
  int   n = 0;
  bit   m_act = 0;
  int   m_owner = 0;
  int   m_exp_at = 0;
  int   m_lock_last = -1;
  logic [6:0] e_vec;
  logic [6:0] obs;
  assign obs = {ack, nack, preempt, expired, active, cur_user};

  task automatic model_reset();
    m_act = 0;
    m_owner = 0;
    m_exp_at = 0;
    m_lock_last = -1;
  endtask

  task automatic cycle(input bit r, input int u, input bit rl);
    bit a, nk, p, x;
    a = 0; nk = 0; p = 0; x = 0;
    @(negedge clk);
    req = r;
    req_user = u[1:0];
    rel = rl;
    @(posedge clk);
    n++;
    if (m_act) begin
      if (rl) begin
        m_act = 0;
        if (r) begin
          m_act = 1; m_owner = u; m_exp_at = n + S; a = 1;
        end
      end else if (r && u > m_owner) begin
        m_owner = u; m_exp_at = n + S; a = 1; p = 1;
      end else if (n == m_exp_at) begin
        m_act = 0; x = 1; nk = r; m_lock_last = n + L;
      end else begin
        nk = r;
      end
    end else if (n <= m_lock_last) begin
      nk = r;
    end else if (r) begin
      m_act = 1; m_owner = u; m_exp_at = n + S; a = 1;
    end
    e_vec = {a, nk, p, x, m_act, m_act ? 2'(m_owner) : 2'b00};
    #1;
    req = 1'b0;
    rel = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = 1'b0;
    rel = 1'b0;
    req_user = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== 7'd0) begin
      errors++;
      $display("FAIL reset_outputs got %b want %b", obs, 7'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_grant();
    apply_reset();
    cycle(1, 2, 0);
    checks++;
    if (obs !== e_vec || ack !== 1'b1 || active !== 1'b1 || cur_user !== 2'd2) begin
      errors++;
      $display("FAIL first_grant got %b want %b", obs, e_vec);
    end
  endtask

  task automatic test_preempt();
    int users[3] = '{1, 2, 3};
    apply_reset();
    cycle(1, 2, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(1, users[i], 0);
      checks++;
      if (obs !== e_vec) begin
        errors++;
        $display("FAIL preempt_u%0d got %b want %b", users[i], obs, e_vec);
      end
    end
    checks++;
    if (preempt !== 1'b1 || cur_user !== 2'd3) begin
      errors++;
      $display("FAIL preempt_final got pre=%b user=%0d want pre=1 user=3", preempt, cur_user);
    end
  endtask

  task automatic test_expiry();
    apply_reset();
    cycle(1, 1, 0);
    for (int i = 1; i <= S; i++) begin
      cycle(0, 0, 0);
      checks++;
      if (obs !== e_vec || expired !== (i == S)) begin
        errors++;
        $display("FAIL expiry_c%0d got %b want %b", i, obs, e_vec);
      end
    end
    checks++;
    if (cur_user !== 2'd0 || active !== 1'b0) begin
      errors++;
      $display("FAIL expiry_clear got user=%0d act=%b want 0 0", cur_user, active);
    end
    for (int i = 1; i <= L + 1; i++) begin
      cycle(1, 3, (i == 2));
      checks++;
      if (obs !== e_vec || ack !== (i == L + 1) || nack !== (i <= L)) begin
        errors++;
        $display("FAIL lockout_r%0d got %b want %b", i, obs, e_vec);
      end
    end
  endtask

  task automatic test_rel_req();
    apply_reset();
    cycle(1, 2, 0);
    cycle(1, 0, 1);
    checks++;
    if (obs !== e_vec || obs !== 7'b1000100) begin
      errors++;
      $display("FAIL rel_req got %b want %b", obs, 7'b1000100);
    end
    cycle(0, 0, 1);
    checks++;
    if (obs !== e_vec || active !== 1'b0) begin
      errors++;
      $display("FAIL rel_only got %b want %b", obs, e_vec);
    end
    cycle(0, 0, 1);
    checks++;
    if (obs !== 7'd0) begin
      errors++;
      $display("FAIL rel_idle got %b want %b", obs, 7'd0);
    end
  endtask

  task automatic test_expiry_race();
    int ru[2] = '{3, 1};
    logic [6:0] want[2] = '{7'b1010111, 7'b0101000};
    for (int k = 0; k < 2; k++) begin
      apply_reset();
      cycle(1, 1, 0);
      repeat (S - 1) cycle(0, 0, 0);
      cycle(1, ru[k], 0);
      checks++;
      if (obs !== e_vec || obs !== want[k]) begin
        errors++;
        $display("FAIL race_u%0d got %b want %b", ru[k], obs, want[k]);
      end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    cycle(1, 3, 0);
    cycle(0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 7'd0) begin
      errors++;
      $display("FAIL async_reset got %b want %b", obs, 7'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cycle(1, 1, 0);
    checks++;
    if (obs !== e_vec || obs !== 7'b1000101) begin
      errors++;
      $display("FAIL post_reset_grant got %b want %b", obs, 7'b1000101);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    apply_reset();
    for (int i = 0; i < 800; i++) begin
      cycle(($urandom_range(0, 7) < 2), $urandom_range(0, 3), ($urandom_range(0, 15) == 0));
      checks++;
      if (obs !== e_vec) begin
        errors++;
        bad++;
        if (bad <= 10) $display("FAIL random_c%0d got %b want %b", i, obs, e_vec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_grant();
    test_preempt();
    test_expiry();
    test_rel_req();
    test_expiry_race();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
